// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage, sits directly after the PC register.
//
// Accepts {pc_i, pc_e_i} and returns one 32-bit instruction per accepted PC.
// Hits in a direct-mapped, one-word-per-line icache return on the next edge.
// Misses are filled from the byte-wide memory controller with four serial
// byte reads assembled little-endian. if_stall_o is combinational so the PC
// register never advances past a PC that is still being fetched.
//
// Configuration macro:
//   ICACHE_EN  defined   -> 2**ICACHE_IDX line icache with hit path
//              undefined -> no storage, every accepted PC is fetched from memory
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   rdy           global ready; 0 freezes every register (icache included)
//   pc_i/pc_e_i   fetch address and its valid
//   flush_i       branch redirect; aborts any fetch in flight, highest priority
//   id_stall_i    decode cannot take an instruction; holds a presented one
//   if_stall_o    stall back to the PC register (combinational)
//   inst_o        fetched instruction
//   inst_pc_o     PC of inst_o
//   inst_valid_o  inst_o/inst_pc_o valid
//   mem_req_o     byte read request
//   mem_addr_o    byte address of the request
//   mem_grant_i   request accepted this cycle
//   mem_din_i     read data, valid the cycle after each grant
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter int ADDR_W     = 32,
    parameter int ICACHE_IDX = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_e_i,
    input  logic              flush_i,
    input  logic              id_stall_i,
    output logic              if_stall_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_grant_i,
    input  logic [7:0]        mem_din_i
);

    localparam int TAG_W = ADDR_W - ICACHE_IDX - 2;
    localparam int LINES = 1 << ICACHE_IDX;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // fpc keeps the PC exactly as presented so inst_pc_o reports it unchanged;
    // the memory address ignores its two low bits.
    logic [ADDR_W-1:0] fpc;
    logic [2:0]        req_cnt;
    logic [1:0]        rcv_cnt;
    logic              rsp_vld_p1;   // a granted byte is on mem_din_i this cycle
    logic [23:0]       byte_buf;     // lanes 0..2; lane 3 goes straight to the output

    logic              hit;
    logic [31:0]       line;
    logic              accept;
    logic              accept_hit;
    logic              accept_miss;
    logic              grant_take;
    logic              fill_done;
    logic [31:0]       fill_word;

    assign accept      = (state == IDLE) && pc_e_i && !id_stall_i && !flush_i;
    assign accept_hit  = accept && hit;
    assign accept_miss = accept && !hit;
    assign grant_take  = (state == FETCH) && mem_req_o && mem_grant_i;
    // A completion coinciding with a flush is dropped, never written back.
    assign fill_done   = (state == FETCH) && rsp_vld_p1 && (rcv_cnt == 2'd3) && !flush_i;
    assign fill_word   = {mem_din_i, byte_buf};

`ifdef ICACHE_EN
    logic [LINES-1:0]      line_vld;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [ICACHE_IDX-1:0] rd_idx;
    logic [ICACHE_IDX-1:0] wr_idx;
    logic [TAG_W-1:0]      rd_tag;
    logic [TAG_W-1:0]      wr_tag;

    assign rd_idx = pc_i[ICACHE_IDX+1:2];
    assign rd_tag = pc_i[ADDR_W-1:ICACHE_IDX+2];
    assign wr_idx = fpc[ICACHE_IDX+1:2];
    assign wr_tag = fpc[ADDR_W-1:ICACHE_IDX+2];
    assign hit    = line_vld[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign line   = data_mem[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_vld <= '0;
        end else if (rdy && fill_done) begin
            line_vld[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && fill_done) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= fill_word;
        end
    end
`else
    assign hit  = 1'b0;
    assign line = '0;
`endif

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        if (rdy) begin
            if (flush_i) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE:    if (accept_miss) state_nxt = FETCH;
                    FETCH:   if (fill_done)   state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // ---- FSM: outputs ----
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        if_stall_o = id_stall_i;
        if (state == FETCH) begin
            if_stall_o = 1'b1;
            if (req_cnt < 3'd4) begin
                mem_req_o  = 1'b1;
                // Wraps modulo 2**ADDR_W by construction.
                mem_addr_o = {fpc[ADDR_W-1:2], 2'b00} + ADDR_W'(req_cnt);
            end
        end else if (pc_e_i && !hit) begin
            if_stall_o = 1'b1;
        end
    end

    // ---- fetch control: byte counters and response tracking ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_cnt    <= '0;
            rcv_cnt    <= '0;
            rsp_vld_p1 <= 1'b0;
        end else if (rdy) begin
            if (flush_i || accept_miss) begin
                // Flush also discards the byte due next cycle.
                req_cnt    <= '0;
                rcv_cnt    <= '0;
                rsp_vld_p1 <= 1'b0;
            end else if (state == FETCH) begin
                rsp_vld_p1 <= grant_take;
                if (grant_take) req_cnt <= req_cnt + 3'd1;
                if (rsp_vld_p1) rcv_cnt <= rcv_cnt + 2'd1;
            end
        end
    end

    // ---- fetch data: miss address and partial line ----
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (accept_miss) fpc <= pc_i;
            if ((state == FETCH) && rsp_vld_p1 && !flush_i) begin
                case (rcv_cnt)
                    2'd0:    byte_buf[7:0]   <= mem_din_i;
                    2'd1:    byte_buf[15:8]  <= mem_din_i;
                    2'd2:    byte_buf[23:16] <= mem_din_i;
                    default: ;
                endcase
            end
        end
    end

    // ---- output stage ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else if (rdy) begin
            if (flush_i) begin
                inst_valid_o <= 1'b0;
            end else if (inst_valid_o && id_stall_i) begin
                inst_valid_o <= 1'b1;
            end else if (fill_done) begin
                inst_o       <= fill_word;
                inst_pc_o    <= fpc;
                inst_valid_o <= 1'b1;
            end else if (accept_hit) begin
                inst_o       <= line;
                inst_pc_o    <= pc_i;
                inst_valid_o <= 1'b1;
            end else begin
                inst_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch : self-checking bench for if_fetch.
// Memory is a fixed byte function of the address; the reference model derives
// every expected instruction from it and tracks icache residency as a map from
// line index to the aligned address it holds (empty when ICACHE_EN is off).
// -----------------------------------------------------------------------------
module tb_if_fetch;

`ifdef ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_i;
    logic        pc_e_i;
    logic        flush_i;
    logic        id_stall_i;
    logic        if_stall_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i;
    logic [7:0]  mem_din_i;

    always #5 clk = ~clk;

    if_fetch #(.ADDR_W(32), .ICACHE_IDX(7)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .pc_e_i(pc_e_i),
        .flush_i(flush_i), .id_stall_i(id_stall_i), .if_stall_o(if_stall_o),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i)
    );

    int          checks = 0;
    int          errors = 0;
    int          gmode  = 0;   // 0: grant always, 1: random grants, 2: 3 idle cycles after each grant
    int          gap    = 0;
    logic [31:0] req_log [$];
    logic [31:0] cache_model [int];

    typedef struct {
        logic [31:0] pc;
        int          gm;
        logic [31:0] exp_inst;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a < 32'd4) begin
            if (a == 32'd0) return 8'h13;
            return 8'h00;
        end
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] b;
        b = {pc[31:2], 2'b00};
        return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
    endfunction

    function automatic int line_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h7F);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int idx;
        idx = line_of(pc);
        if (!CACHE_ON) return 1'b0;
        return cache_model.exists(idx) && (cache_model[idx] == {pc[31:2], 2'b00});
    endfunction

    function automatic void model_fill(input logic [31:0] pc);
        if (CACHE_ON) cache_model[line_of(pc)] = {pc[31:2], 2'b00};
    endfunction

    // One clock with the memory-controller behaviour: grant policy, logging
    // of granted addresses, and the byte returned the cycle after a grant.
    task automatic tick();
        logic        g;
        logic        r;
        logic [31:0] a;
        #1;
        if (!rdy)                mem_grant_i = 1'b0;
        else if (gmode == 0)     mem_grant_i = 1'b1;
        else if (gmode == 1)     mem_grant_i = 1'($urandom_range(0, 1));
        else if (gap > 0) begin  mem_grant_i = 1'b0; gap--; end
        else                     mem_grant_i = 1'b1;
        #1;
        g = mem_req_o & mem_grant_i & rdy;
        a = mem_addr_o;
        r = rdy;
        if (g) begin
            req_log.push_back(a);
            if (gmode == 2) gap = 3;
        end
        @(posedge clk);
        #1;
        if (r) mem_din_i = g ? mem_byte(a) : 8'($urandom);
    endtask

    task automatic present(input logic [31:0] pc, input int gm);
        gmode = gm;
        gap = 0;
        pc_i = pc;
        pc_e_i = 1'b1;
        id_stall_i = 1'b0;
        flush_i = 1'b0;
        req_log.delete();
    endtask

    task automatic wait_valid(inout int lat, output int stall_bad);
        stall_bad = 0;
        while (!inst_valid_o && lat < 100) begin
            if (!if_stall_o) stall_bad++;
            tick();
            lat++;
        end
        chk("valid_seen", 32'(inst_valid_o), 32'd1);
    endtask

    task automatic chk_miss_reqs(input logic [31:0] pc);
        logic [31:0] b;
        b = {pc[31:2], 2'b00};
        chk("miss_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            chk("miss_req_addr", req_log[i], b + 32'(i));
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int gm, output logic [31:0] got);
        bit exp_hit;
        int lat;
        int stall_bad;
        exp_hit = model_hit(pc);
        present(pc, gm);
        #1;
        chk("stall_at_present", 32'(if_stall_o), 32'(!exp_hit));
        tick();
        pc_e_i = 1'b0;
        pc_i = $urandom;
        lat = 1;
        wait_valid(lat, stall_bad);
        got = inst_o;
        chk("inst", inst_o, word_at(pc));
        chk("inst_pc", inst_pc_o, pc);
        if (exp_hit) begin
            chk("hit_latency", 32'(lat), 32'd1);
            chk("hit_no_mem_req", 32'(req_log.size()), 32'd0);
        end else begin
            chk("stall_during_fetch", 32'(stall_bad), 32'd0);
            chk_miss_reqs(pc);
            // Acceptance edge plus five fetch cycles with back-to-back grants.
            if (gm == 0) chk("miss_latency", 32'(lat), 32'd6);
            model_fill(pc);
        end
        tick();
        chk("valid_pulse", 32'(inst_valid_o), 32'd0);
    endtask

    // Start a miss at pc, assert flush after k edges (k<=5 keeps it before
    // completion with back-to-back grants), present a fresh PC in the flush
    // cycle, and confirm nothing is delivered.
    task automatic flush_fetch(input logic [31:0] pc, input int k, input int gm);
        int seen;
        present(pc, gm);
        repeat (k) begin
            tick();
            pc_e_i = 1'b0;
        end
        flush_i = 1'b1;
        pc_e_i = 1'b1;
        pc_i = 32'h0000_5000;
        tick();
        flush_i = 1'b0;
        pc_e_i = 1'b0;
        chk("flush_valid", 32'(inst_valid_o), 32'd0);
        chk("flush_mem_req", 32'(mem_req_o), 32'd0);
        seen = 0;
        repeat (3) begin
            tick();
            if (inst_valid_o || mem_req_o) seen++;
        end
        chk("flush_quiet", 32'(seen), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rdy = 1'b1;
        pc_e_i = 1'b0;
        flush_i = 1'b0;
        id_stall_i = 1'b0;
        pc_i = '0;
        mem_grant_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_pc", inst_pc_o, 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        rst = 1'b1;
        cache_model.delete();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] pool [8];
        int          lat;
        int          stall_bad;
        logic [31:0] held_addr;

        vecs[0] = '{pc: 32'h0000_0000, gm: 0, exp_inst: 32'h0000_0013};
        vecs[1] = '{pc: 32'h0000_0100, gm: 0, exp_inst: 32'hB7B6_B5B4};
        vecs[2] = '{pc: 32'h0000_0200, gm: 2, exp_inst: 32'h8485_8687};
        vecs[3] = '{pc: 32'h0000_03AB, gm: 1, exp_inst: 32'h3D3C_3F3E};
        vecs[4] = '{pc: 32'hFFFF_FFFC, gm: 0, exp_inst: 32'hA5A4_A7A6};

        mem_din_i = '0;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            do_fetch(vecs[i].pc, vecs[i].gm, got);
            chk("table_inst", got, vecs[i].exp_inst);
        end

        // Cold fetch, refetch, alias at 0x200 with gapped grants, alias back.
        do_reset();
        do_fetch(32'h0, 0, got);
        chk("first_fetch", got, 32'h0000_0013);
        do_fetch(32'h0, 0, got);
        do_fetch(32'h200, 2, got);
        do_fetch(32'h0, 0, got);

        // Flush after two bytes of 0x40, then a full refetch.
        flush_fetch(32'h40, 4, 0);
        do_fetch(32'h40, 0, got);

        // Flush landing on the completion cycle of 0x100.
        do_reset();
        flush_fetch(32'h100, 5, 0);
        do_fetch(32'h100, 0, got);

        // Decode stall holds the presented instruction and blocks acceptance.
        present(32'h300, 0);
        tick();
        pc_e_i = 1'b0;
        lat = 1;
        wait_valid(lat, stall_bad);
        model_fill(32'h300);
        id_stall_i = 1'b1;
        pc_e_i = 1'b1;
        pc_i = 32'h100;
        repeat (3) begin
            tick();
            chk("hold_valid", 32'(inst_valid_o), 32'd1);
            chk("hold_inst", inst_o, word_at(32'h300));
            chk("hold_pc", inst_pc_o, 32'h300);
            chk("hold_stall", 32'(if_stall_o), 32'd1);
            chk("hold_no_req", 32'(mem_req_o), 32'd0);
        end
        id_stall_i = 1'b0;
        pc_e_i = 1'b0;
        tick();
        chk("release_valid", 32'(inst_valid_o), 32'd0);

        // rdy low mid-fetch freezes the request and the partial line.
        present(32'h700, 0);
        tick();
        pc_e_i = 1'b0;
        tick();
        held_addr = mem_addr_o;
        rdy = 1'b0;
        repeat (3) begin
            tick();
            chk("frz_addr", mem_addr_o, held_addr);
            chk("frz_req", 32'(mem_req_o), 32'd1);
            chk("frz_valid", 32'(inst_valid_o), 32'd0);
        end
        rdy = 1'b1;
        lat = 3;
        wait_valid(lat, stall_bad);
        chk("frz_inst", inst_o, word_at(32'h700));
        chk_miss_reqs(32'h700);
        model_fill(32'h700);
        tick();

        // Asynchronous reset in the middle of a fetch.
        present(32'h600, 0);
        repeat (3) begin
            tick();
            pc_e_i = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_inst", inst_o, 32'd0);
        chk("arst_inst_pc", inst_pc_o, 32'd0);
        chk("arst_valid", 32'(inst_valid_o), 32'd0);
        chk("arst_mem_req", 32'(mem_req_o), 32'd0);
        chk("arst_mem_addr", mem_addr_o, 32'd0);
        chk("arst_stall", 32'(if_stall_o), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cache_model.delete();
        #1;
        do_fetch(32'h600, 0, got);

        // Random traffic over a small aliasing address pool.
        for (int i = 0; i < 8; i++)
            pool[i] = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 2)
                      | 32'($urandom_range(0, 3));
        for (int n = 0; n < 40; n++) begin
            logic [31:0] p;
            int          gm;
            p = pool[$urandom_range(0, 7)];
            gm = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0 && !model_hit(p))
                flush_fetch(p, $urandom_range(1, 5), gm);
            else
                do_fetch(p, gm, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
